// File: rtl/rob_commit.sv
// Reorder buffer: dual-slot allocate, dual-port writeback, in-order dual commit.
// Optional ROB_WB_BYPASS_EN lets same-cycle writebacks to head/head+1 commit immediately.
module rob_commit #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_req_0,
    input  logic             alloc_req_1,
    input  logic [4:0]       alloc_rd_0,
    input  logic [4:0]       alloc_rd_1,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag_0,
    output logic [TAG_W-1:0] alloc_tag_1,
    input  logic             wb_valid_0,
    input  logic             wb_valid_1,
    input  logic [TAG_W-1:0] wb_tag_0,
    input  logic [TAG_W-1:0] wb_tag_1,
    input  logic [XLEN-1:0]  wb_data_0,
    input  logic [XLEN-1:0]  wb_data_1,
    output logic             commit_we_0,
    output logic             commit_we_1,
    output logic [4:0]       commit_addr_0,
    output logic [4:0]       commit_addr_1,
    output logic [TAG_W-1:0] commit_tag_0,
    output logic [TAG_W-1:0] commit_tag_1,
    output logic [XLEN-1:0]  commit_data_0,
    output logic [XLEN-1:0]  commit_data_1,
    output logic [TAG_W:0]   count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [4:0]       rd   [DEPTH];
    logic [XLEN-1:0]  data [DEPTH];

    logic [TAG_W-1:0] head, tail, head_1, tail_1;
    logic             alloc_0, alloc_1;
    logic [1:0]       n_alloc, n_commit;
    logic             done_h0, done_h1;

    assign head_1 = head + TAG_W'(1);
    assign tail_1 = tail + TAG_W'(1);

    assign alloc_ready = (count <= (TAG_W+1)'(DEPTH-2));
    assign alloc_tag_0 = tail;
    assign alloc_tag_1 = tail_1;

    assign alloc_0  = alloc_req_0 & alloc_ready & ~flush;
    assign alloc_1  = alloc_0 & alloc_req_1;
    assign n_alloc  = {1'b0, alloc_0} + {1'b0, alloc_1};
    assign n_commit = {1'b0, commit_we_0} + {1'b0, commit_we_1};

    // Head-entry completion and data, optionally forwarded from this cycle's writebacks
    always_comb begin
        done_h0       = done[head];
        done_h1       = done[head_1];
        commit_data_0 = data[head];
        commit_data_1 = data[head_1];
`ifdef ROB_WB_BYPASS_EN
        if (wb_valid_0 && wb_tag_0 == head) begin
            done_h0       = 1'b1;
            commit_data_0 = wb_data_0;
        end
        if (wb_valid_1 && wb_tag_1 == head) begin
            done_h0       = 1'b1;
            commit_data_0 = wb_data_1;
        end
        if (wb_valid_0 && wb_tag_0 == head_1) begin
            done_h1       = 1'b1;
            commit_data_1 = wb_data_0;
        end
        if (wb_valid_1 && wb_tag_1 == head_1) begin
            done_h1       = 1'b1;
            commit_data_1 = wb_data_1;
        end
`endif
    end

    assign commit_we_0   = ~flush & valid[head] & done_h0;
    assign commit_we_1   = commit_we_0 & valid[head_1] & done_h1;
    assign commit_addr_0 = rd[head];
    assign commit_addr_1 = rd[head_1];
    assign commit_tag_0  = head;
    assign commit_tag_1  = head_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd[i]   <= '0;
                data[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            // Port 1 is applied last so it wins a same-tag collision
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && wb_valid_0 && wb_tag_0 == TAG_W'(i)) begin
                    done[i] <= 1'b1;
                    data[i] <= wb_data_0;
                end
                if (valid[i] && wb_valid_1 && wb_tag_1 == TAG_W'(i)) begin
                    done[i] <= 1'b1;
                    data[i] <= wb_data_1;
                end
            end
            if (commit_we_0) valid[head]   <= 1'b0;
            if (commit_we_1) valid[head_1] <= 1'b0;
            // Allocation only targets free slots, so it never collides with commit or writeback
            if (alloc_0) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                rd[tail]    <= alloc_rd_0;
            end
            if (alloc_1) begin
                valid[tail_1] <= 1'b1;
                done[tail_1]  <= 1'b0;
                rd[tail_1]    <= alloc_rd_1;
            end
            head  <= head + TAG_W'(n_commit);
            tail  <= tail + TAG_W'(n_alloc);
            count <= count + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_commit);
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Randomized bench for rob_commit against a queue-based reorder-buffer model.
// Honours ROB_WB_BYPASS_EN in the model when the macro is defined.
module tb_rob_commit;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             alloc_req_0 = 1'b0, alloc_req_1 = 1'b0;
    logic [4:0]       alloc_rd_0 = '0, alloc_rd_1 = '0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag_0, alloc_tag_1;
    logic             wb_valid_0 = 1'b0, wb_valid_1 = 1'b0;
    logic [TAG_W-1:0] wb_tag_0 = '0, wb_tag_1 = '0;
    logic [XLEN-1:0]  wb_data_0 = '0, wb_data_1 = '0;
    logic             commit_we_0, commit_we_1;
    logic [4:0]       commit_addr_0, commit_addr_1;
    logic [TAG_W-1:0] commit_tag_0, commit_tag_1;
    logic [XLEN-1:0]  commit_data_0, commit_data_1;
    logic [TAG_W:0]   count;

    rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
        .alloc_rd_0(alloc_rd_0), .alloc_rd_1(alloc_rd_1),
        .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
        .wb_tag_0(wb_tag_0), .wb_tag_1(wb_tag_1),
        .wb_data_0(wb_data_0), .wb_data_1(wb_data_1),
        .commit_we_0(commit_we_0), .commit_we_1(commit_we_1),
        .commit_addr_0(commit_addr_0), .commit_addr_1(commit_addr_1),
        .commit_tag_0(commit_tag_0), .commit_tag_1(commit_tag_1),
        .commit_data_0(commit_data_0), .commit_data_1(commit_data_1),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          rd;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_tail = 0;
    endtask

    // Does this entry count as done this cycle, and with which data?
    task automatic headView(input ent_t e, input bit wv0, input int wt0, input logic [31:0] wd0,
                            input bit wv1, input int wt1, input logic [31:0] wd1,
                            output bit d, output logic [31:0] v);
        d = e.done;
        v = e.data;
`ifdef ROB_WB_BYPASS_EN
        if (wv0 && wt0 == e.tag) begin d = 1; v = wd0; end
        if (wv1 && wt1 == e.tag) begin d = 1; v = wd1; end
`endif
    endtask

    task automatic applyStimulus(input bit fl, input bit ar0, input bit ar1, input int rd0, input int rd1,
                                 input bit wv0, input int wt0, input logic [31:0] wd0,
                                 input bit wv1, input int wt1, input logic [31:0] wd1);
        bit          ready, we0, we1, d;
        logic [31:0] v0, v1;
        ent_t        e;
        @(negedge clk);
        flush = fl;
        alloc_req_0 = ar0; alloc_req_1 = ar1;
        alloc_rd_0 = rd0[4:0]; alloc_rd_1 = rd1[4:0];
        wb_valid_0 = wv0; wb_tag_0 = wt0[TAG_W-1:0]; wb_data_0 = wd0;
        wb_valid_1 = wv1; wb_tag_1 = wt1[TAG_W-1:0]; wb_data_1 = wd1;
        #1;
        ready = (q.size() <= DEPTH - 2);
        checkOutput("count", count, q.size());
        checkOutput("alloc_ready", alloc_ready, ready);
        checkOutput("alloc_tag_0", alloc_tag_0, m_tail);
        checkOutput("alloc_tag_1", alloc_tag_1, (m_tail + 1) % DEPTH);
        we0 = 0; we1 = 0; v0 = '0; v1 = '0;
        if (!fl && q.size() > 0) begin
            headView(q[0], wv0, wt0, wd0, wv1, wt1, wd1, d, v0);
            we0 = d;
        end
        if (we0 && q.size() > 1) begin
            headView(q[1], wv0, wt0, wd0, wv1, wt1, wd1, d, v1);
            we1 = d;
        end
        checkOutput("commit_we_0", commit_we_0, we0);
        checkOutput("commit_we_1", commit_we_1, we1);
        if (we0) begin
            checkOutput("commit_tag_0", commit_tag_0, q[0].tag);
            checkOutput("commit_addr_0", commit_addr_0, q[0].rd);
            checkOutput("commit_data_0", commit_data_0, v0);
        end
        if (we1) begin
            checkOutput("commit_tag_1", commit_tag_1, q[1].tag);
            checkOutput("commit_addr_1", commit_addr_1, q[1].rd);
            checkOutput("commit_data_1", commit_data_1, v1);
        end
        if (fl) begin
            modelReset();
        end else begin
            foreach (q[i]) begin
                if (wv0 && wt0 == q[i].tag) begin q[i].done = 1; q[i].data = wd0; end
                if (wv1 && wt1 == q[i].tag) begin q[i].done = 1; q[i].data = wd1; end
            end
            if (we0) void'(q.pop_front());
            if (we1) void'(q.pop_front());
            if (ready && ar0) begin
                e = '{tag: m_tail, rd: rd0 & 31, done: 0, data: 0};
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
                if (ar1) begin
                    e = '{tag: m_tail, rd: rd1 & 31, done: 0, data: 0};
                    q.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_commit_we_0", commit_we_0, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_alloc_ready", alloc_ready, 1);
        checkOutput("rst_alloc_tag_0", alloc_tag_0, 0);
        checkOutput("rst_alloc_tag_1", alloc_tag_1, 1);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_commit_we_1", commit_we_1, 0);
        @(negedge clk);
        flush = 0; alloc_req_0 = 0; alloc_req_1 = 0; wb_valid_0 = 0; wb_valid_1 = 0;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int wt0, wt1;
        modelReset();
        #1;
        checkOutput("por_count", count, 0);
        checkOutput("por_alloc_ready", alloc_ready, 1);
        checkOutput("por_alloc_tag_1", alloc_tag_1, 1);
        checkOutput("por_commit_we_0", commit_we_0, 0);
        doReset();

        // Fill 14 entries two per cycle; tag 0 carries rd=0
        for (int c = 0; c < 7; c++) applyStimulus(0, 1, 1, 2*c, 2*c+1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("fill_count", count, 14);

        // Out-of-order completion: tag 1 then tag 0, both commit together
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h1111_0001, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h1111_0000, 0, 0, 0);
        idle();

        // Refill to 14, then commit two while allocating two (tail wraps)
        applyStimulus(0, 1, 1, 7, 8, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h2222_0002, 1, 3, 32'h2222_0003);
        applyStimulus(0, 1, 1, 9, 10, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("wrap_count", count, 14);

        // Five done entries behind a pending head, then flush
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'h5, 1, 6, 32'h6);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h7, 1, 8, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h9, 1, 9, 32'h99);
        applyStimulus(1, 1, 1, 3, 4, 1, 4, 32'h4, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("flush_count", count, 0);
        checkOutput("flush_alloc_tag_0", alloc_tag_0, 0);

        // Writeback to head with a known word
        applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        idle();

        // Randomized traffic with occasional flush and asynchronous reset
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                wt0 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size()-1)].tag
                                                                   : int'($urandom_range(0, DEPTH-1));
                wt1 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size()-1)].tag
                                                                   : int'($urandom_range(0, DEPTH-1));
                applyStimulus($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
                              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                              int'($urandom_range(0, 31)),
                              1'($urandom), wt0, $urandom, 1'($urandom), wt1, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
